// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling, framing-error detection and break hold-off.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_signal,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  state_t state, state_nx;
  logic [1:0] sync;
  logic rx_s;
  logic [CW-1:0] clk_cnt, cnt_nx;
  logic [2:0] bit_idx, idx_nx;
  logic [7:0] shreg, sh_nx, data_nx;
  logic valid_nx, ferr_nx;
  assign rx_s = sync[1];
  assign o_busy = state != IDLE;
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      sync        <= 2'b11;
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      sync        <= {sync[0], i_signal};
      state       <= state_nx;
      clk_cnt     <= cnt_nx;
      bit_idx     <= idx_nx;
      shreg       <= sh_nx;
      o_data      <= data_nx;
      o_valid     <= valid_nx;
      o_frame_err <= ferr_nx;
    end
  end
  // Bit timer free-runs in the timed states and is cleared at every sample point.
  always_comb begin
    state_nx = state;
    cnt_nx   = clk_cnt + 1'b1;
    idx_nx   = bit_idx;
    sh_nx    = shreg;
    data_nx  = o_data;
    valid_nx = 1'b0;
    ferr_nx  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (!rx_s) state_nx = START;
      end
      START: if (clk_cnt == HALF) begin
        cnt_nx   = '0;
        idx_nx   = '0;
        state_nx = rx_s ? IDLE : DATA;
      end
      DATA: if (clk_cnt == LAST) begin
        cnt_nx = '0;
        sh_nx  = {rx_s, shreg[7:1]};
        idx_nx = bit_idx + 1'b1;
        if (bit_idx == 3'd7) state_nx = STOP;
      end
      STOP: if (clk_cnt == LAST) begin
        cnt_nx   = '0;
        valid_nx = rx_s;
        ferr_nx  = !rx_s;
        data_nx  = rx_s ? shreg : o_data;
        state_nx = rx_s ? IDLE : BREAK;
      end
      BREAK: begin
        cnt_nx = '0;
        if (rx_s) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: random and directed frames against a byte-level scoreboard.
module tb_uart_rx;
  localparam int N = 16;
  logic i_clock = 1'b0, i_reset_n = 1'b0, i_signal = 1'b1;
  logic [7:0] o_data;
  logic o_valid, o_frame_err, o_busy;
  typedef struct {bit err; logic [7:0] data;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0, last_v = 0, prev_v = 0;
  bit busy_seen = 0;
  logic [7:0] last_good = 8'h00;

  uart_rx #(.CLKS_PER_BIT(N)) dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_signal(i_signal),
    .o_data(o_data), .o_valid(o_valid), .o_frame_err(o_frame_err), .o_busy(o_busy)
  );

  always #5 i_clock = ~i_clock;
  always @(posedge i_clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge i_clock);
      if (o_busy) busy_seen = 1;
      if (o_valid && o_frame_err) check("valid_and_ferr", 1, 0);
      if (o_valid || o_frame_err) begin
        if (q.size() == 0) check("unexpected_strobe", {o_valid, o_frame_err}, 0);
        else begin
          e = q.pop_front();
          check("strobe_kind", o_frame_err, e.err);
          check("strobe_data", o_data, e.data);
        end
        if (o_valid) begin
          prev_v = last_v;
          last_v = cyc;
        end
      end
    end
  endtask

  task automatic drive_bit(input logic v, input int clks);
    i_signal = v;
    repeat (clks) @(negedge i_clock);
  endtask

  // Reference model: a good stop bit delivers the byte, a bad one repeats the last good byte.
  task automatic send_frame(input logic [7:0] d, input bit stop);
    exp_t e;
    e.err  = !stop;
    e.data = stop ? d : last_good;
    if (stop) last_good = d;
    q.push_back(e);
    drive_bit(1'b0, N);
    for (int i = 0; i < 8; i++) drive_bit(d[i], N);
    drive_bit(stop, N);
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    i_signal  = 1'b1;
    repeat (3) @(negedge i_clock);
    i_reset_n = 1'b1;
    last_good = 8'h00;
  endtask

  initial begin
    logic [7:0] b;
    bit s;
    fork monitor(); join_none
    @(negedge i_clock);
    do_reset();
    check("rst_data", o_data, 8'h00);
    check("rst_valid", o_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_ferr", o_frame_err, 0);
    drive_bit(1'b1, 4);
    send_frame(8'hA5, 1);
    check("a5_busy_after", o_busy, 0);
    check("a5_drained", q.size(), 0);
    drive_bit(1'b1, N);
    busy_seen = 0;
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 30);
    check("glitch_busy_seen", busy_seen, 1);
    check("glitch_idle", o_busy, 0);
    send_frame(8'h3C, 0);
    drive_bit(1'b0, 24);
    check("break_busy", o_busy, 1);
    drive_bit(1'b1, 4);
    check("break_released", o_busy, 0);
    check("ferr_keeps_data", o_data, 8'hA5);
    drive_bit(1'b1, N);
    send_frame(8'h00, 1);
    send_frame(8'hFF, 1);
    drive_bit(1'b1, N);
    check("b2b_spacing", last_v - prev_v, 160);
    check("b2b_data", o_data, 8'hFF);
    drive_bit(1'b0, N);
    b = 8'h5A;
    for (int i = 0; i < 4; i++) drive_bit(b[i], N);
    drive_bit(b[4], N / 2);
    do_reset();
    check("midreset_data", o_data, 8'h00);
    check("midreset_busy", o_busy, 0);
    drive_bit(1'b1, 2 * N);
    send_frame(8'h81, 1);
    drive_bit(1'b1, 4);
    check("after_reset_data", o_data, 8'h81);
    for (int k = 0; k < 24; k++) begin
      b = 8'($urandom);
      s = $urandom_range(0, 3) != 0;
      send_frame(b, s);
      drive_bit(1'b1, s ? $urandom_range(0, 20) : $urandom_range(2, 20));
    end
    drive_bit(1'b1, 2 * N);
    check("final_drained", q.size(), 0);
    check("final_data", o_data, last_good);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
